// File: rtl/frame_cell_if.sv
// Ingress-side and core-side signals of the frame cell segmenter.
// The master modport is the segmenter; the slave modport is its environment.
interface frame_cell_if;
   logic         hdr_valid;
   logic         hdr_ready;
   logic [11:0]  hdr_len;
   logic [3:0]   hdr_portmap;
   logic [127:0] in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [127:0] cell_data_din;
   logic         cell_data_wr;
   logic [15:0]  cell_ptr_din;
   logic         cell_ptr_wr;
   logic         cell_bp;
   logic [15:0]  drop_cnt;

   modport master (
      input  hdr_valid, hdr_len, hdr_portmap, in_data, in_valid, in_last, cell_bp,
      output hdr_ready, in_ready, cell_data_din, cell_data_wr, cell_ptr_din,
             cell_ptr_wr, drop_cnt
   );

   modport slave (
      output hdr_valid, hdr_len, hdr_portmap, in_data, in_valid, in_last, cell_bp,
      input  hdr_ready, in_ready, cell_data_din, cell_data_wr, cell_ptr_din,
             cell_ptr_wr, drop_cnt
   );
endinterface

// File: rtl/frame_cell_segmenter.sv
// Cuts descriptor-plus-data frames into 64-byte cells for the switch core,
// zero-pads the last cell and then writes one pointer word per frame.
module frame_cell_segmenter #(
   parameter int MAX_LEN        = 1536,
   parameter int WORDS_PER_CELL = 4
) (
   input logic        clk,
   input logic        rst,
   frame_cell_if.master bus
);

   typedef enum logic [2:0] {IDLE, DATA, PAD, PTR, DROP} state_t;

   localparam logic [11:0] MAX_LEN_W  = 12'(MAX_LEN);
   localparam int          CELL_SHIFT = $clog2(WORDS_PER_CELL);

   state_t        state_q, state_d;
   logic [7:0]    word_cnt_q, word_cnt_d;
   logic [7:0]    exp_words_q, exp_words_d;
   logic [5:0]    cells_q, cells_d;
   logic [3:0]    portmap_q, portmap_d;
   logic [127:0]  data_din_q, data_din_d;
   logic          data_wr_q, data_wr_d;
   logic [15:0]   ptr_din_q, ptr_din_d;
   logic          ptr_wr_q, ptr_wr_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic          hdr_ready_c, in_ready_c;

   logic          hdr_bad;
   logic [7:0]    tot_words;
   logic [7:0]    cnt_inc;
   logic [7:0]    cnt_after;

   assign hdr_bad   = (bus.hdr_portmap == 4'd0) || (bus.hdr_len == 12'd0) ||
                      (bus.hdr_len > MAX_LEN_W);
   assign tot_words = 8'({2'b00, cells_q} << CELL_SHIFT);
   assign cnt_inc   = word_cnt_q + 8'd1;
   // Words beyond the descriptor length are swallowed without advancing the count.
   assign cnt_after = (word_cnt_q < exp_words_q) ? cnt_inc : word_cnt_q;

   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      exp_words_d = exp_words_q;
      cells_d     = cells_q;
      portmap_d   = portmap_q;
      data_din_d  = data_din_q;
      data_wr_d   = 1'b0;
      ptr_din_d   = ptr_din_q;
      ptr_wr_d    = 1'b0;
      drop_cnt_d  = drop_cnt_q;
      hdr_ready_c = 1'b0;
      in_ready_c  = 1'b0;
      case (state_q)
         IDLE: begin
            hdr_ready_c = bus.hdr_valid && !bus.cell_bp;
            if (hdr_ready_c) begin
               if (hdr_bad) begin
                  state_d = DROP;
                  if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
               end else begin
                  state_d     = DATA;
                  word_cnt_d  = 8'd0;
                  exp_words_d = 8'(({1'b0, bus.hdr_len} + 13'd15) >> 4);
                  cells_d     = 6'(({1'b0, bus.hdr_len} + 13'd63) >> 6);
                  portmap_d   = bus.hdr_portmap;
               end
            end
         end
         DATA: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               if (word_cnt_q < exp_words_q) begin
                  data_wr_d  = 1'b1;
                  data_din_d = bus.in_data;
               end
               word_cnt_d = cnt_after;
               if (bus.in_last) state_d = (cnt_after == tot_words) ? PTR : PAD;
            end
         end
         PAD: begin
            data_wr_d  = 1'b1;
            data_din_d = 128'h0;
            word_cnt_d = cnt_inc;
            if (cnt_inc == tot_words) state_d = PTR;
         end
         PTR: begin
            // Registered strobe lands one cycle after the final data write.
            ptr_wr_d  = 1'b1;
            ptr_din_d = {4'b0000, portmap_q, 2'b00, cells_q};
            state_d   = IDLE;
         end
         DROP: begin
            in_ready_c = 1'b1;
            if (bus.in_valid && bus.in_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         word_cnt_q  <= 8'd0;
         exp_words_q <= 8'd0;
         cells_q     <= 6'd0;
         portmap_q   <= 4'd0;
         data_din_q  <= 128'h0;
         data_wr_q   <= 1'b0;
         ptr_din_q   <= 16'h0;
         ptr_wr_q    <= 1'b0;
         drop_cnt_q  <= 16'h0;
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         exp_words_q <= exp_words_d;
         cells_q     <= cells_d;
         portmap_q   <= portmap_d;
         data_din_q  <= data_din_d;
         data_wr_q   <= data_wr_d;
         ptr_din_q   <= ptr_din_d;
         ptr_wr_q    <= ptr_wr_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign bus.hdr_ready     = hdr_ready_c && !rst;
   assign bus.in_ready      = in_ready_c;
   assign bus.cell_data_din = data_din_q;
   assign bus.cell_data_wr  = data_wr_q;
   assign bus.cell_ptr_din  = ptr_din_q;
   assign bus.cell_ptr_wr   = ptr_wr_q;
   assign bus.drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_frame_cell_segmenter.sv
// Directed-vector bench for frame_cell_segmenter: frame table plus
// backpressure, reset and counter-saturation sequences.
module tb_frame_cell_segmenter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   frame_cell_if bus();

   frame_cell_segmenter #(.MAX_LEN(1536), .WORDS_PER_CELL(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [11:0] len;
      logic [3:0]  pm;
      int          nw;
      int          ndata;
      int          npad;
      logic [15:0] ptr;
      bit          drop;
   } vec_t;

   vec_t         vecs[9];
   int           errors = 0;
   int           checks = 0;
   logic [127:0] data_q[$];
   logic [15:0]  ptr_q[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] word(input int f, input int i);
      return {8'(f), 8'(i), 112'h0123_4567_89ab_cdef_fedc_ba98_7654};
   endfunction

   // Capture core-side writes away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.cell_data_wr) data_q.push_back(bus.cell_data_din);
         if (bus.cell_ptr_wr) begin
            ptr_q.push_back(bus.cell_ptr_din);
            chk("ptr_not_with_data", {127'b0, bus.cell_data_wr}, 128'd0);
         end
         if (bus.hdr_ready) chk("hdr_in_excl", {127'b0, bus.in_ready}, 128'd0);
      end
   end

   task automatic send_hdr(input logic [11:0] len, input logic [3:0] pm);
      int t;
      @(negedge clk);
      bus.hdr_len = len; bus.hdr_portmap = pm; bus.hdr_valid = 1'b1;
      #1;
      t = 0;
      while (!bus.hdr_ready && t < 50) begin @(negedge clk); #1; t++; end
      chk("hdr_accept", {127'b0, bus.hdr_ready}, 128'd1);
      @(posedge clk); #1;
      bus.hdr_valid = 1'b0;
   endtask

   task automatic send_words(input int f, input int n);
      int t;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.in_data = word(f, i); bus.in_valid = 1'b1; bus.in_last = (i == n - 1);
         #1;
         t = 0;
         while (!bus.in_ready && t < 20) begin @(negedge clk); #1; t++; end
         if (!bus.in_ready) chk("in_ready_timeout", {127'b0, bus.in_ready}, 128'd1);
         @(posedge clk); #1;
         bus.in_valid = 1'b0; bus.in_last = 1'b0;
      end
   endtask

   task automatic check_frame(input int f, input int ndata, input int npad,
                              input logic [15:0] ptr);
      int t;
      int n;
      t = 0;
      while (ptr_q.size() == 0 && t < 300) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      chk("data_writes", 128'(data_q.size()), 128'(ndata + npad));
      n = (data_q.size() < ndata + npad) ? data_q.size() : ndata + npad;
      for (int i = 0; i < n; i++)
         chk((i < ndata) ? "data_word" : "pad_word", data_q[i],
             (i < ndata) ? word(f, i) : 128'h0);
      chk("ptr_writes", 128'(ptr_q.size()), 128'd1);
      if (ptr_q.size() > 0) chk("ptr_value", {112'b0, ptr_q[0]}, {112'b0, ptr});
      data_q.delete(); ptr_q.delete();
   endtask

   task automatic check_drop();
      repeat (3) @(negedge clk);
      chk("drop_no_data", 128'(data_q.size()), 128'd0);
      chk("drop_no_ptr", 128'(ptr_q.size()), 128'd0);
      data_q.delete(); ptr_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{12'd64,   4'b0010, 4,  4,  0,  16'h0201, 1'b0};
      vecs[1] = '{12'd100,  4'b1001, 7,  7,  1,  16'h0902, 1'b0};
      vecs[2] = '{12'd200,  4'b0001, 5,  5,  11, 16'h0104, 1'b0};
      vecs[3] = '{12'd64,   4'b0100, 6,  4,  0,  16'h0401, 1'b0};
      vecs[4] = '{12'd1,    4'b0011, 1,  1,  3,  16'h0301, 1'b0};
      vecs[5] = '{12'd1536, 4'b1111, 96, 96, 0,  16'h0F18, 1'b0};
      vecs[6] = '{12'd64,   4'b0000, 4,  0,  0,  16'h0000, 1'b1};
      vecs[7] = '{12'd1537, 4'b0001, 3,  0,  0,  16'h0000, 1'b1};
      vecs[8] = '{12'd0,    4'b0001, 2,  0,  0,  16'h0000, 1'b1};

      bus.hdr_valid = 1'b0; bus.hdr_len = '0; bus.hdr_portmap = '0;
      bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.cell_bp = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("rst_data_wr",  {127'b0, bus.cell_data_wr}, 128'd0);
      chk("rst_ptr_wr",   {127'b0, bus.cell_ptr_wr}, 128'd0);
      chk("rst_in_ready", {127'b0, bus.in_ready}, 128'd0);
      chk("rst_hdr_ready",{127'b0, bus.hdr_ready}, 128'd0);
      chk("rst_drop_cnt", {112'b0, bus.drop_cnt}, 128'd0);

      for (int v = 0; v < 9; v++) begin
         send_hdr(vecs[v].len, vecs[v].pm);
         send_words(v, vecs[v].nw);
         if (vecs[v].drop) check_drop();
         else check_frame(v, vecs[v].ndata, vecs[v].npad, vecs[v].ptr);
      end
      chk("drop_cnt_3", {112'b0, bus.drop_cnt}, 128'd3);

      // Backpressure holds off admission; lowering it admits in the same cycle.
      @(negedge clk);
      bus.cell_bp = 1'b1; bus.hdr_len = 12'd100; bus.hdr_portmap = 4'b1001; bus.hdr_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("bp_hdr_ready_low", {127'b0, bus.hdr_ready}, 128'd0);
         @(negedge clk);
      end
      bus.cell_bp = 1'b0;
      #1;
      chk("bp_release_ready", {127'b0, bus.hdr_ready}, 128'd1);
      @(posedge clk); #1;
      bus.hdr_valid = 1'b0; bus.cell_bp = 1'b1;
      send_words(20, 7);
      check_frame(20, 7, 1, 16'h0902);
      bus.cell_bp = 1'b0;

      // Reset mid-frame abandons it without a pointer write.
      send_hdr(12'd200, 4'b0001);
      send_words(30, 2);
      @(negedge clk);
      bus.hdr_valid = 1'b1; bus.hdr_len = 12'd64; bus.hdr_portmap = 4'b0001;
      rst = 1'b1;
      #1;
      chk("mid_rst_data_wr",  {127'b0, bus.cell_data_wr}, 128'd0);
      chk("mid_rst_ptr_wr",   {127'b0, bus.cell_ptr_wr}, 128'd0);
      chk("mid_rst_in_ready", {127'b0, bus.in_ready}, 128'd0);
      chk("mid_rst_hdr_ready",{127'b0, bus.hdr_ready}, 128'd0);
      chk("mid_rst_drop_cnt", {112'b0, bus.drop_cnt}, 128'd0);
      chk("mid_rst_din",      bus.cell_data_din, 128'd0);
      chk("mid_rst_ptr_din",  {112'b0, bus.cell_ptr_din}, 128'd0);
      bus.hdr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      data_q.delete(); ptr_q.delete();
      repeat (5) @(negedge clk);
      chk("post_rst_no_ptr", 128'(ptr_q.size()), 128'd0);
      chk("post_rst_no_data", 128'(data_q.size()), 128'd0);
      send_hdr(12'd100, 4'b1001);
      send_words(40, 7);
      check_frame(40, 7, 1, 16'h0902);

      // Drop counter saturates at all-ones.
      @(negedge clk);
      force dut.drop_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.drop_cnt_q;
      #1;
      chk("preload_ffff", {112'b0, bus.drop_cnt}, 128'hFFFF);
      send_hdr(12'd64, 4'b0000);
      send_words(50, 2);
      check_drop();
      chk("drop_cnt_sat", {112'b0, bus.drop_cnt}, 128'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
